// File: rtl/sync_counter_pkg.sv
// Shared constants and types for the sync_counter block.
// The optional build macro SYNC_COUNTER_SATURATE_EN is consumed by
// sync_counter_next; nothing in this package depends on it.
package sync_counter_pkg;

  // Counter width used when the instantiating level does not override WIDTH.
  localparam int DEFAULT_WIDTH = 6;

  // Which operation produces the next count value.
  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    INC   = 3'd3,
    DEC   = 3'd4
  } next_op_e;

endpackage

// File: rtl/sync_counter_next.sv
// Next-value logic for sync_counter: prioritised operation select
// (clear > load > count > hold) and the wrap-or-saturate arithmetic.
// Build option: define SYNC_COUNTER_SATURATE_EN to make counting stop at
// all-ones (up) and zero (down); by default counting wraps modulo 2^WIDTH.
// Reset is not handled here; the register in the top level owns it.
module sync_counter_next
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] parallelLoad,
  input  logic             clear,
  input  logic             load_en,
  input  logic             cnt_en,
  input  logic             upDown_n,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  next_op_e op;

  // Pick the operation by fixed priority; load wins over counting.
  always_comb begin
    op = HOLD;
    if (clear) begin
      op = CLEAR;
    end else if (load_en) begin
      op = LOAD;
    end else if (cnt_en) begin
      op = upDown_n ? INC : DEC;
    end
  end

  // Compute the value for the chosen operation, wrapping or saturating at the ends.
  always_comb begin
    next_count = count;
    case (op)
      CLEAR: next_count = '0;
      LOAD:  next_count = parallelLoad;
`ifdef SYNC_COUNTER_SATURATE_EN
      INC:   next_count = (count == {WIDTH{1'b1}}) ? count : count + ONE;
      DEC:   next_count = (count == '0) ? count : count - ONE;
`else
      INC:   next_count = count + ONE;
      DEC:   next_count = count - ONE;
`endif
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/sync_counter.sv
// Synchronous up/down counter with clear, parallel load and a
// terminal-count compare against a programmable threshold.
// Build option: SYNC_COUNTER_SATURATE_EN (see sync_counter_next).
// The count register drives parallelOutput directly; terminalCount is a
// purely combinational compare so it tracks threashold with no latency.
module sync_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] parallelLoad,
  input  logic [WIDTH-1:0] threashold,
  input  logic             upDown_n,
  input  logic             load_en,
  input  logic             cnt_en,
  output logic             terminalCount,
  output logic [WIDTH-1:0] parallelOutput
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] next_count;

  sync_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count        (count),
    .parallelLoad (parallelLoad),
    .clear        (clear),
    .load_en      (load_en),
    .cnt_en       (cnt_en),
    .upDown_n     (upDown_n),
    .next_count   (next_count)
  );

  // Count register; synchronous active-low reset overrides every other control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

  assign parallelOutput = count;
  assign terminalCount  = (count == threashold);

endmodule

// File: tb/tb_sync_counter.sv
// Self-checking bench for sync_counter (WIDTH=6): a table of directed
// vectors, hand-written multi-cycle sequences, then randomized traffic
// compared against an arithmetic reference model.
module tb_sync_counter;

  localparam int W    = 6;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [W-1:0] parallelLoad;
  logic [W-1:0] threashold;
  logic         upDown_n;
  logic         load_en;
  logic         cnt_en;
  logic         terminalCount;
  logic [W-1:0] parallelOutput;

  int checks_total;
  int checks_passed;

  sync_counter #(
    .WIDTH (W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .parallelLoad   (parallelLoad),
    .threashold     (threashold),
    .upDown_n       (upDown_n),
    .load_en        (load_en),
    .cnt_en         (cnt_en),
    .terminalCount  (terminalCount),
    .parallelOutput (parallelOutput)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         rst_n;
    logic         clear;
    logic         load_en;
    logic         cnt_en;
    logic         up;
    logic [W-1:0] load_val;
    logic [W-1:0] thr;
    logic [W-1:0] exp_count;
    logic         exp_tc;
  } vec_t;

  vec_t vecs[12];

  // Reference: next count from the priority rules using plain integer arithmetic.
  function automatic int modelNext(int cur, bit r, bit c, bit l, bit e, bit up, int pl);
    if (!r) return 0;
    if (c) return 0;
    if (l) return pl;
    if (e) begin
`ifdef SYNC_COUNTER_SATURATE_EN
      if (up) return (cur == MAXV) ? MAXV : cur + 1;
      else    return (cur == 0) ? 0 : cur - 1;
`else
      if (up) return (cur + 1) % (MAXV + 1);
      else    return (cur + MAXV) % (MAXV + 1);
`endif
    end
    return cur;
  endfunction

  // Drive one cycle of inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic l, input logic e,
                               input logic up, input logic [W-1:0] pl, input logic [W-1:0] thr);
    @(negedge clk);
    rst_n        = r;
    clear        = c;
    load_en      = l;
    cnt_en       = e;
    upDown_n     = up;
    parallelLoad = pl;
    threashold   = thr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_count, input logic exp_tc);
    checks_total++;
    if (parallelOutput === exp_count) checks_passed++;
    else $display("[TB] FAIL %s count: got %0d, expected %0d", name, parallelOutput, exp_count);
    checks_total++;
    if (terminalCount === exp_tc) checks_passed++;
    else $display("[TB] FAIL %s terminalCount: got %0b, expected %0b", name, terminalCount, exp_tc);
  endtask

  task automatic checkTc(input string name, input logic exp_tc);
    checks_total++;
    if (terminalCount === exp_tc) checks_passed++;
    else $display("[TB] FAIL %s terminalCount: got %0b, expected %0b", name, terminalCount, exp_tc);
  endtask

  initial begin
    int model;
    logic [W-1:0] exp_w;
    checks_total  = 0;
    checks_passed = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    load_en      = 1'b0;
    cnt_en       = 1'b0;
    upDown_n     = 1'b1;
    parallelLoad = '0;
    threashold   = '0;

    //                rst clr ld  en  up  load  thr  count tc
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd6,  6'd0,  6'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd6,  6'd1,  6'd6, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd1,  6'd5, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd1,  6'd4, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd1,  6'd3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd1,  6'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd1,  6'd1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd9,  6'd1,  6'd0, 1'b0};
`ifdef SYNC_COUNTER_SATURATE_EN
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd63, 6'd0,  1'b0};
`else
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd63, 6'd63, 1'b1};
`endif
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd63, 6'd63, 6'd63, 1'b1};
`ifdef SYNC_COUNTER_SATURATE_EN
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd63, 6'd63, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd63, 1'b0};
`else
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd63, 6'd0,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1};
`endif

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].clear, vecs[i].load_en, vecs[i].cnt_en,
                    vecs[i].up, vecs[i].load_val, vecs[i].thr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc);
    end

    // Hold with upDown_n toggling, and terminalCount tracking threashold between edges.
    $display("[TB] hold and threshold tracking");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd20, 6'd0);
    checkOutput("load20", 6'd20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, logic'(i[0]), 6'd33, 6'd0);
      checkOutput($sformatf("hold%0d", i), 6'd20, 1'b0);
    end
    @(negedge clk);
    threashold = 6'd20;
    #1;
    checkTc("thr_eq", 1'b1);
    threashold = 6'd21;
    #1;
    checkTc("thr_ne", 1'b0);

    // Reset in the middle of counting discards the count.
    $display("[TB] mid-count reset");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 6'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd12);
    checkOutput("up12", 6'd12, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd40, 6'd0);
    checkOutput("midreset", 6'd0, 1'b1);

    // Randomized traffic against the arithmetic model.
    $display("[TB] random traffic");
    model = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, c, l, e, up;
      logic [W-1:0] pl, thr;
      r   = ($urandom_range(0, 19) != 0);
      c   = ($urandom_range(0, 14) == 0);
      l   = ($urandom_range(0, 5) == 0);
      e   = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      pl  = ($urandom_range(0, 3) == 0) ? W'(MAXV) : W'($urandom_range(0, MAXV));
      thr = W'($urandom_range(0, MAXV));
      model = modelNext(model, r, c, l, e, up, int'(pl));
      applyStimulus(r, c, l, e, up, pl, thr);
      exp_w = W'(model);
      checkOutput($sformatf("rand%0d", i), exp_w, (exp_w == thr));
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sync_counter.md
SYNC_COUNTER -- requirements
Module: sync_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, counter and operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1, synchronous clear of the count to zero.
REQ-005 The block SHALL have port parallelLoad, input, WIDTH, the value loaded when load_en is high.
REQ-006 The block SHALL have port threashold, input, WIDTH, the compare value for terminalCount.
REQ-007 The block SHALL have port upDown_n, input, 1; 1 selects count up, 0 selects count down.
REQ-008 The block SHALL have port load_en, input, 1, the parallel-load enable.
REQ-009 The block SHALL have port cnt_en, input, 1, the count enable.
REQ-010 The block SHALL have port terminalCount, output, 1, high while the count equals threashold.
REQ-011 The block SHALL have port parallelOutput, output, WIDTH, the registered count value.

Function
REQ-012 On each rising clk edge, the next count SHALL be selected by fixed priority: rst_n low, then clear high, then load_en high, then cnt_en high, else hold.
REQ-013 When clear is high, the count SHALL become 0 on the next edge.
REQ-014 When load_en is high, the count SHALL become parallelLoad on the next edge; cnt_en and upDown_n are ignored that cycle.
REQ-015 When only cnt_en is high, the count SHALL become count+1 if upDown_n=1, or count-1 if upDown_n=0.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH by default: up from all-ones gives 0, and down from 0 gives all-ones.
REQ-017 terminalCount SHALL be combinational, equal to (parallelOutput == threashold), with zero latency from the count register or from a threashold change.
REQ-018 parallelOutput SHALL be driven directly from the count register with no combinational path from the inputs.
REQ-019 X or Z on control inputs is unsupported; the bench SHALL drive known values.

Reset
REQ-020 When rst_n is low at a rising clk edge, the count SHALL become 0, overriding all other controls.
REQ-021 Before the first clock edge with rst_n low, the outputs are undefined.
REQ-022 After reset, terminalCount SHALL equal (threashold == 0).
REQ-023 A reset mid-count SHALL take effect on the next edge with no other state retained.

Configuration
REQ-024 With macro SYNC_COUNTER_SATURATE_EN defined, counting SHALL saturate: up holds at all-ones and down holds at 0; load and clear are unaffected.
REQ-025 Without SYNC_COUNTER_SATURATE_EN defined, counting SHALL wrap as in REQ-016.

Structure
REQ-026 Package sync_counter_pkg SHALL hold the default-width constant and an enum for the next-value operation (HOLD, CLEAR, LOAD, INC, DEC).
REQ-027 The combinational next-value selection and the saturate/wrap logic SHALL be placed in sub-module sync_counter_next; the top level holds the register and the compare.

Verification (WIDTH=6)
REQ-028 Hold rst_n=0 for one edge with load_en=1 and cnt_en=1 -> parallelOutput=0.
REQ-029 Set load_en=1, parallelLoad=6 (and cnt_en=1 in the same cycle) -> parallelOutput=6 after one edge, with no count applied.
REQ-030 From 6, drive cnt_en=1, upDown_n=0, threashold=1 for five edges -> count sequence 5,4,3,2,1, with terminalCount=1 exactly when the count is 1.
REQ-031 Drive clear=1 together with load_en=1 -> parallelOutput=0, since clear wins.
REQ-032 From 0, drive cnt_en=1, upDown_n=0 -> result 63 by default, or 0 with SYNC_COUNTER_SATURATE_EN; from 63 counting up -> 0, or 63 with the macro.
REQ-033 Drive cnt_en=0, load_en=0, and toggle upDown_n -> the count holds, and terminalCount follows threashold changes in the same cycle.
